// File: rtl/dispatch_vrp_pkg.sv
// rtl/dispatch_vrp_pkg.sv - shared constants and onehot helpers for the round-robin dispatcher
package dispatch_vrp_pkg;

    localparam int CNT_WIDTH = 16;
    // Upper bound on WIDTH supported by rotl1's fixed-width argument
    localparam int MAX_WIDTH = 64;

    // Rotate the low w bits of a onehot vector left by one, wrapping bit w-1 to bit 0
    function automatic logic [MAX_WIDTH-1:0] rotl1(input logic [MAX_WIDTH-1:0] v, input int w);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < w) begin
                r[(i + 1 == w) ? 0 : i + 1] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dispatch_vrp_rr_if.sv
// rtl/dispatch_vrp_rr_if.sv - 1:N stream bundle; v_cnt_m present only with DISPATCH_VRP_CNT_EN
interface dispatch_vrp_rr_if #(
    parameter int WIDTH     = 4,
    parameter int PLD_WIDTH = 32
);
    import dispatch_vrp_pkg::*;

    logic                 vld_s;
    logic                 rdy_s;
    logic [PLD_WIDTH-1:0] pld_s;
    logic [WIDTH-1:0]     v_vld_m;
    logic [WIDTH-1:0]     v_rdy_m;
    logic [PLD_WIDTH-1:0] v_pld_m [WIDTH];
`ifdef DISPATCH_VRP_CNT_EN
    logic [CNT_WIDTH-1:0] v_cnt_m [WIDTH];
`endif

    // Dispatcher side: consumes the input stream, produces the output streams
    modport slave (
        input  vld_s, pld_s, v_rdy_m,
        output rdy_s, v_vld_m, v_pld_m
`ifdef DISPATCH_VRP_CNT_EN
        , output v_cnt_m
`endif
    );

    // Environment side: producer plus replicated consumers
    modport master (
        output vld_s, pld_s, v_rdy_m,
        input  rdy_s, v_vld_m, v_pld_m
`ifdef DISPATCH_VRP_CNT_EN
        , input v_cnt_m
`endif
    );

endinterface

// File: rtl/dispatch_vrp_rr_pick.sv
// rtl/dispatch_vrp_rr_pick.sv - circular priority picker: first requester at or after ptr
module rr_pick_onehot #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] ptr,
    output logic [WIDTH-1:0] gnt
);
    logic [2*WIDTH-1:0] req2;
    logic [2*WIDTH-1:0] ptr2;
    logic [2*WIDTH-1:0] hit2;

    // Doubling req turns the wrap-around scan into a linear one; subtracting the
    // onehot ptr clears the lowest set bit at or above ptr, which the mask isolates.
    always_comb begin
        req2 = {req, req};
        ptr2 = {{WIDTH{1'b0}}, ptr};
        hit2 = req2 & ~(req2 - ptr2);
        gnt  = hit2[WIDTH-1:0] | hit2[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/dispatch_vrp_rr.sv
// rtl/dispatch_vrp_rr.sv - 1:N round-robin dispatcher with one registered slot per output; DISPATCH_VRP_CNT_EN adds beat counters
module dispatch_vrp_rr
    import dispatch_vrp_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PLD_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dispatch_vrp_rr_if.slave  bus
);
    logic [WIDTH-1:0]     slot_full;
    logic [PLD_WIDTH-1:0] slot_pld [WIDTH];
    logic [WIDTH-1:0]     ptr;
    logic [WIDTH-1:0]     free;
    logic [WIDTH-1:0]     sel;
    logic [WIDTH-1:0]     ptr_next;
    logic [MAX_WIDTH-1:0] sel_rot;
    logic                 rdy;
    logic                 accept;

    // A slot draining this cycle is reusable, so back-to-back beats see no bubble
    always_comb begin
        free     = ~slot_full | bus.v_rdy_m;
        rdy      = |free;
        accept   = bus.vld_s & rdy;
        sel_rot  = rotl1(MAX_WIDTH'(sel), WIDTH);
        ptr_next = sel_rot[WIDTH-1:0];
    end

    rr_pick_onehot #(.WIDTH(WIDTH)) u_pick (
        .req (free),
        .ptr (ptr),
        .gnt (sel)
    );

    // Slot fill/drain; a load in the same cycle as a drain wins and keeps the slot full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                slot_pld[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (accept && sel[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_pld[i]  <= bus.pld_s;
                end else if (slot_full[i] && bus.v_rdy_m[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    // Priority pointer moves just past the slot that was loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= WIDTH'(1);
        end else if (accept) begin
            ptr <= ptr_next;
        end
    end

    assign bus.rdy_s   = rdy;
    assign bus.v_vld_m = slot_full;
    assign bus.v_pld_m = slot_pld;

`ifdef DISPATCH_VRP_CNT_EN
    logic [CNT_WIDTH-1:0] cnt [WIDTH];

    // Per-output delivered-beat counters, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (slot_full[i] && bus.v_rdy_m[i] && (cnt[i] != {CNT_WIDTH{1'b1}})) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.v_cnt_m = cnt;
`endif

endmodule
